jk_counter: RTL

Synchronous modulo-N counter built from a row of JK toggle cells. Each bit is a JK flip-flop driven in hold/set/reset/toggle mode, so the block is the direct consumer of the toggle-mode JK behaviour our JK cell already provides. Every bit switches on the same clock edge, with none of the ripple delay of a cascaded divider. The block produces the count value, a terminal-count flag and a carry-out for cascading, and sits downstream of the clock source as a divider or event counter.

---
 rtl/jk_pkg.sv | 25 ++
 rtl/jk_cell.sv | 31 +++
 rtl/jk_counter.sv | 97 +++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared JK cell command encoding for the JK-based counter.
// The command bits are {j, k}, so they can be wired straight to a cell.
package jk_pkg;

   localparam int MAX_WIDTH = 16;

   typedef enum logic [1:0] {
      HOLD = 2'b00,
      RST  = 2'b01,
      SET  = 2'b10,
      TOG  = 2'b11
   } jk_mode_t;

   // Loads use set/reset so the loaded value does not depend on the current bit.
   // Counting uses only hold or toggle.
   function automatic jk_mode_t jk_mode(input logic cur, input logic nxt, input logic load);
      if (load)
         return nxt ? SET : RST;
      else if (cur != nxt)
         return TOG;
      else
         return HOLD;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop.
// It has a synchronous active-high reset to 0.
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   logic q_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg <= 1'b0;
      end else begin
         case (jk_mode_t'({j, k}))
            HOLD:    q_reg <= q_reg;
            RST:     q_reg <= 1'b0;
            SET:     q_reg <= 1'b1;
            TOG:     q_reg <= ~q_reg;
            default: q_reg <= q_reg;
         endcase
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/jk_counter.sv
// Synchronous modulo-MODULUS counter built from WIDTH JK cells.
// Define JK_COUNTER_DOWN_EN to let the up port select the count direction.
module jk_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             co,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic             wrap_next;
   logic             ovf_reg;

   always_comb begin
      q_next    = q_reg;
      wrap_next = 1'b0;
      if (load) begin
         q_next = (load_val > MAX_Q) ? MAX_Q : load_val;
      end else if (en) begin
         // Out-of-range states recover to 0 on the next step.
         if (q_reg > MAX_Q) begin
            q_next = '0;
         end
`ifdef JK_COUNTER_DOWN_EN
         else if (!up) begin
            if (q_reg == '0) begin
               q_next    = MAX_Q;
               wrap_next = 1'b1;
            end else begin
               q_next = q_reg - WIDTH'(1);
            end
         end
`endif
         else if (q_reg == MAX_Q) begin
            q_next    = '0;
            wrap_next = 1'b1;
         end else begin
            q_next = q_reg + WIDTH'(1);
         end
      end
   end

   // Turn each bit's current-to-next transition into a JK command.
   // Then drive one cell per bit with that command.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [1:0] cmd_bits;
         assign cmd_bits = jk_mode(q_reg[gi], q_next[gi], load);

         jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (cmd_bits[1]),
            .k   (cmd_bits[0]),
            .q   (q_reg[gi])
         );
      end
   endgenerate

   // A wrap in the same cycle as clr_ovf leaves ovf set.
   always_ff @(posedge clk) begin
      if (rst)
         ovf_reg <= 1'b0;
      else if (wrap_next)
         ovf_reg <= 1'b1;
      else if (clr_ovf)
         ovf_reg <= 1'b0;
   end

`ifdef JK_COUNTER_DOWN_EN
   assign tc = up ? (q_reg == MAX_Q) : (q_reg == '0);
`else
   logic unused_up;
   assign unused_up = up;
   assign tc        = (q_reg == MAX_Q);
`endif

   assign co  = en & tc;
   assign q   = q_reg;
   assign ovf = ovf_reg;

endmodule
